// File: rtl/spi_lcd_rx_if.sv
// CPU-side io handshake and status bundle for the LCD SPI receiver.
interface spi_lcd_rx_if;
  logic       req;
  logic       nwr;
  logic [8:0] data_out;
  logic       ack;
  logic       empty;
  logic       full;
  logic       overrun;
  logic       interrupt;
  logic       interrupt_clear;

  modport master (
    output req, nwr, interrupt_clear,
    input  data_out, ack, empty, full, overrun, interrupt
  );

  modport slave (
    input  req, nwr, interrupt_clear,
    output data_out, ack, empty, full, overrun, interrupt
  );
endinterface

// File: rtl/spi_lcd_rx.sv
// Mode-0 SPI slave receiver: oversamples the LCD link, assembles {dc, byte} words into a FIFO
// that the CPU drains over a req/ack handshake.
module spi_lcd_rx #(
  parameter int unsigned FIFO_BITS = 4
) (
  input logic          clk,
  input logic          nreset,
  input logic          sck,
  input logic          mosi,
  input logic          ncs,
  input logic          dc,
  spi_lcd_rx_if.slave  io
);

  localparam int unsigned Depth = 1 << FIFO_BITS;

  typedef enum logic {StIdle, StAck} io_state_e;

  logic [2:0]           sck_q;
  logic [1:0]           mosi_q, ncs_q, dc_q;
  logic [2:0]           bit_cnt_q;
  logic [6:0]           shift_q;
  logic [8:0]           mem_q [Depth];
  logic [FIFO_BITS:0]   wr_ptr_q, rd_ptr_q;
  logic                 overrun_q, interrupt_q, ack_q;
  logic [8:0]           data_q;
  io_state_e            state_q;

  logic                 sck_rise, word_done, empty, full, io_start, pop, push;
  logic [8:0]           word;

  always_comb begin
    sck_rise  = sck_q[1] & ~sck_q[2];
    word_done = sck_rise & ~ncs_q[1] & (bit_cnt_q == 3'd7);
    // dc is taken at the 8th edge, not at the start of the byte
    word      = {dc_q[1], shift_q, mosi_q[1]};
    empty     = (wr_ptr_q == rd_ptr_q);
    full      = (wr_ptr_q[FIFO_BITS] != rd_ptr_q[FIFO_BITS]) &&
                (wr_ptr_q[FIFO_BITS-1:0] == rd_ptr_q[FIFO_BITS-1:0]);
    io_start  = (state_q == StIdle) & io.req;
    pop       = io_start & io.nwr & ~empty;
    // a pop on the same edge frees the slot, so a push into a full FIFO is still accepted
    push      = word_done & (~full | pop);
  end

  // Synchronizers and bit assembly
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      sck_q     <= 3'b000;
      mosi_q    <= 2'b00;
      ncs_q     <= 2'b11;
      dc_q      <= 2'b00;
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
    end else begin
      sck_q  <= {sck_q[1:0], sck};
      mosi_q <= {mosi_q[0], mosi};
      ncs_q  <= {ncs_q[0], ncs};
      dc_q   <= {dc_q[0], dc};
      if (ncs_q[1]) begin
        bit_cnt_q <= 3'd0;
      end else if (sck_rise) begin
        shift_q   <= {shift_q[5:0], mosi_q[1]};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_BITS-1:0]] <= word;
    end
  end

  // FIFO pointers and sticky flags
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      overrun_q   <= 1'b0;
      interrupt_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (word_done && !push) begin
        overrun_q <= 1'b1;
      end else if (io_start && !io.nwr) begin
        overrun_q <= 1'b0;
      end
      if (io.interrupt_clear) begin
        interrupt_q <= 1'b0;
      end else if (push && empty) begin
        interrupt_q <= 1'b1;
      end
    end
  end

  // io handshake: one action per req assertion
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      ack_q   <= 1'b0;
      data_q  <= 9'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (io.req) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
            if (io.nwr) begin
              data_q <= empty ? 9'd0 : mem_q[rd_ptr_q[FIFO_BITS-1:0]];
            end
          end
        end
        StAck: begin
          if (!io.req) begin
            state_q <= StIdle;
            ack_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign io.data_out  = data_q;
  assign io.ack       = ack_q;
  assign io.empty     = empty;
  assign io.full      = full;
  assign io.overrun   = overrun_q;
  assign io.interrupt = interrupt_q;

endmodule

// File: tb/tb_spi_lcd_rx.sv
// Directed bench for spi_lcd_rx (4-entry FIFO) with a queue scoreboard of expected words.
module tb_spi_lcd_rx;
  localparam int unsigned FifoBits = 2;
  localparam int unsigned Depth    = 1 << FifoBits;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic sck = 1'b0, mosi = 1'b0, ncs = 1'b1, dc = 1'b0;
  int   tests = 0, fails = 0;
  logic [8:0] exp_q [$];
  logic [8:0] d;
  logic       ok;

  spi_lcd_rx_if io ();

  spi_lcd_rx #(.FIFO_BITS(FifoBits)) dut (
    .clk    (clk),
    .nreset (nreset),
    .sck    (sck),
    .mosi   (mosi),
    .ncs    (ncs),
    .dc     (dc),
    .io     (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [8:0] w);
    if (exp_q.size() < Depth) exp_q.push_back(w);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    sck  = 1'b0;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dcv);
    dc = dcv;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sb_push({dcv, b});
  endtask

  task automatic start_frame();
    sck = 1'b0;
    ncs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_frame();
    sck = 1'b0;
    repeat (2) @(negedge clk);
    ncs = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // One req/ack transaction; returns the data_out captured while ack is high
  task automatic do_io(input logic rd, output logic [8:0] dv);
    logic seen;
    @(negedge clk);
    io.req = 1'b1;
    io.nwr = rd;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (io.ack) begin seen = 1'b1; break; end
    end
    check("ack_rise", {8'd0, seen}, 9'd1);
    dv = io.data_out;
    io.req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!io.ack) begin seen = 1'b1; break; end
    end
    check("ack_fall", {8'd0, seen}, 9'd1);
  endtask

  task automatic read_check(input string tag);
    logic [8:0] dv, ev;
    do_io(1'b1, dv);
    ev = (exp_q.size() > 0) ? exp_q.pop_front() : 9'd0;
    check(tag, dv, ev);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    io.interrupt_clear = 1'b1;
    @(negedge clk);
    io.interrupt_clear = 1'b0;
  endtask

  initial begin
    io.req = 1'b0;
    io.nwr = 1'b1;
    io.interrupt_clear = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_empty", {8'd0, io.empty}, 9'd1);
    check("rst_full", {8'd0, io.full}, 9'd0);
    check("rst_overrun", {8'd0, io.overrun}, 9'd0);
    check("rst_irq", {8'd0, io.interrupt}, 9'd0);
    check("rst_ack", {8'd0, io.ack}, 9'd0);
    check("rst_data", io.data_out, 9'd0);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Single command byte
    start_frame();
    send_byte(8'hA5, 1'b1);
    check("push_latency_empty", {8'd0, io.empty}, 9'd0);
    end_frame();
    check("irq_set", {8'd0, io.interrupt}, 9'd1);
    read_check("rd_1a5");
    check("empty_after_rd", {8'd0, io.empty}, 9'd1);
    pulse_clear();
    check("irq_cleared", {8'd0, io.interrupt}, 9'd0);

    // Back-to-back data bytes in one frame
    start_frame();
    send_byte(8'h3C, 1'b0);
    send_byte(8'h81, 1'b0);
    end_frame();
    read_check("rd_03c");
    read_check("rd_081");

    // Partial byte is discarded on ncs rising
    start_frame();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    end_frame();
    start_frame();
    send_byte(8'h7E, 1'b0);
    end_frame();
    read_check("rd_07e");
    read_check("rd_empty_zero");
    check("empty_after_partial", {8'd0, io.empty}, 9'd1);

    // Overflow: 5 bytes into 4 entries
    start_frame();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b0);
    end_frame();
    check("full_set", {8'd0, io.full}, 9'd1);
    check("overrun_set", {8'd0, io.overrun}, 9'd1);
    for (int i = 0; i < 4; i++) read_check("rd_overflow_order");
    check("empty_after_drain", {8'd0, io.empty}, 9'd1);
    check("overrun_sticky", {8'd0, io.overrun}, 9'd1);
    do_io(1'b0, d);
    check("overrun_clear", {8'd0, io.overrun}, 9'd0);

    // Long req: ack from the 2nd clk until req falls, one pop only
    pulse_clear();
    start_frame();
    send_byte(8'h66, 1'b0);
    send_byte(8'h77, 1'b0);
    end_frame();
    @(negedge clk);
    io.req = 1'b1;
    io.nwr = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!io.ack) ok = 1'b0;
    end
    check("ack_held", {8'd0, ok}, 9'd1);
    check("rd_long_066", io.data_out, exp_q.pop_front());
    io.req = 1'b0;
    @(negedge clk);
    check("ack_drop", {8'd0, io.ack}, 9'd0);
    read_check("rd_077");
    read_check("rd_empty_again");

    // Clear wins over a simultaneous set; no re-set while non-empty
    pulse_clear();
    io.interrupt_clear = 1'b1;
    start_frame();
    send_byte(8'h99, 1'b1);
    io.interrupt_clear = 1'b0;
    @(negedge clk);
    check("irq_clear_wins", {8'd0, io.interrupt}, 9'd0);
    send_byte(8'h9A, 1'b1);
    end_frame();
    check("irq_no_reset", {8'd0, io.interrupt}, 9'd0);
    read_check("rd_199");
    read_check("rd_19a");

    // Push coinciding with pop while full
    start_frame();
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    check("full_before_race", {8'd0, io.full}, 9'd1);
    dc = 1'b1;
    for (int i = 7; i >= 1; i--) send_bit(1'(8'hC5 >> i));
    mosi = 1'b1;
    sck  = 1'b0;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    @(negedge clk);
    do_io(1'b1, d);
    check("race_pop", d, exp_q.pop_front());
    exp_q.push_back(9'h1C5);
    end_frame();
    check("race_overrun", {8'd0, io.overrun}, 9'd0);
    check("race_full", {8'd0, io.full}, 9'd1);
    for (int i = 0; i < 4; i++) read_check("rd_race_drain");

    // Reset mid-byte while every output is non-default
    pulse_clear();
    start_frame();
    send_byte(8'hB1, 1'b1);
    send_byte(8'hB2, 1'b0);
    send_byte(8'hB3, 1'b0);
    send_byte(8'hB4, 1'b0);
    send_byte(8'hB5, 1'b0);
    @(negedge clk);
    io.req = 1'b1;
    io.nwr = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_data", io.data_out, 9'h1B1);
    check("pre_rst_overrun", {8'd0, io.overrun}, 9'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2 nreset = 1'b0;
    #1;
    check("mid_rst_empty", {8'd0, io.empty}, 9'd1);
    check("mid_rst_full", {8'd0, io.full}, 9'd0);
    check("mid_rst_overrun", {8'd0, io.overrun}, 9'd0);
    check("mid_rst_irq", {8'd0, io.interrupt}, 9'd0);
    check("mid_rst_ack", {8'd0, io.ack}, 9'd0);
    check("mid_rst_data", io.data_out, 9'd0);
    io.req = 1'b0;
    sck = 1'b0;
    ncs = 1'b1;
    exp_q.delete();
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    start_frame();
    send_byte(8'h5A, 1'b1);
    end_frame();
    check("post_rst_irq", {8'd0, io.interrupt}, 9'd1);
    read_check("rd_post_rst_15a");
    check("post_rst_empty", {8'd0, io.empty}, 9'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
